fetch_queue: RTL
================

# fetch_queue

Instruction queue between the Fetch stage and the Decode stage of the 5-stage MIPS pipeline. Each cycle it captures the fetched PC, instruction word and fetch exception code, and presents the oldest entry to Decode through a valid/ready handshake. It back-pressures Fetch through its pause input when full. It discards all in-flight entries on a branch, eret or exception redirect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- F_valid  in  1  Fetch presents an entry this cycle
- F_PC  in  32  PC of fetched instruction
- F_instr  in  32  instruction word read from IM at F_PC
- F_exc  in  5  fetch exception code (0 = none, 4 = AdEL)
- F_pause  out  1  stall request to Fetch; equals full
- flush  in  1  redirect: discard all entries
- D_ready  in  1  Decode consumes head entry this cycle
- D_valid  out  1  head entry valid (queue non-empty)
- D_PC  out  32  head PC
- D_instr  out  32  head instruction
- D_exc  out  5  head exception code
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries {PC, instr, exc}; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register tracks occupancy.
- full = (count == DEPTH); empty = (count == 0); F_pause = full; D_valid = !empty.
- push = F_valid && !full. Writes {F_PC, F_instr or 0, F_exc} at wp, then wp+1. When F_exc != 0, instr is stored as 32'h0 (nop), so a faulting fetch never decodes as a real instruction.
- pop = D_ready && !empty. Advances rp by 1. D_ready while empty is ignored.
- push and pop in the same cycle: both happen and count is unchanged. Push is never accepted while full, even if pop happens that cycle. F_pause has no combinational path from D_ready.
- flush has priority. In a flush cycle: wp = rp = 0, count = 0, and any push or pop in that cycle is dropped. The next cycle D_valid = 0 and F_pause = 0.
- Outputs are read combinationally from entry[rp]. While empty, D_PC, D_instr and D_exc are forced to 0.
- No bypass: an entry pushed in cycle n is visible on D_* no earlier than cycle n+1.
- reset (low, any time, asynchronous): wp = rp = count = 0 and all entry storage cleared to 0. Outputs immediately read D_valid = 0, D_PC = 0, D_instr = 0, D_exc = 0, F_pause = 0, count = 0. This holds while reset is low.

## Timing
- Latency: Fetch to Decode is 1 cycle minimum when the queue is empty and D_ready = 1.
- Throughput: 1 entry per cycle sustained when D_ready = 1 every cycle.
- count update per edge, absent flush and reset: +1 on push only, −1 on pop only, 0 when both or neither.
- After full asserts, F_pause = 1 from the same edge. Fetch must hold F_PC, and its F_valid is ignored until a pop drops count below DEPTH. F_pause falls on the edge following that pop.
- flush sampled at edge n: from edge n, count = 0, D_valid = 0, F_pause = 0. A new entry pushed in cycle n+1 appears at edge n+2.
- Release of reset is asynchronous-assert / synchronous-use. The first push is accepted on the first rising edge with reset high.

## Test plan
- Fill: DEPTH=4, D_ready=0, push PCs 0x3000, 0x3004, 0x3008, 0x300c, then F_valid=1 with 0x3010 -> count=4, F_pause=1, 0x3010 not stored. D_PC=0x3000.
- Drain in order: from full, D_ready=1 for 4 cycles -> D_PC sequence 0x3000, 0x3004, 0x3008, 0x300c. Then D_valid=0, D_PC=0, count=0. F_pause falls one edge after the first pop.
- Streaming with wrap: F_valid=1 and D_ready=1 for 10 cycles, PCs from 0x3000 step 4 -> count held at 1. Each D_PC equals the PC pushed one cycle earlier; no loss or reorder across pointer wrap.
- Flush priority: count=3, and in the same cycle flush=1, F_valid=1 (0x4000), D_ready=1 -> next cycle count=0, D_valid=0. 0x4000 is never presented. A push of 0x5000 the next cycle is visible as D_PC=0x5000 one cycle later.
- Fetch exception: push F_PC=0x3002, F_instr=0x8c010000, F_exc=4 -> D_PC=0x3002, D_exc=4, D_instr=0.
- Reset mid-operation: count=2, drive reset low between edges -> D_valid, count, F_pause and D_* go to 0 immediately. After release, the first pushed entry appears as the head.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-Decode instruction queue: circular buffer with valid/ready output,
// full back-pressure to Fetch, and whole-queue discard on redirect.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       F_valid,
    input  logic [31:0]                F_PC,
    input  logic [31:0]                F_instr,
    input  logic [4:0]                 F_exc,
    output logic                       F_pause,
    input  logic                       flush,
    input  logic                       D_ready,
    output logic                       D_valid,
    output logic [31:0]                D_PC,
    output logic [31:0]                D_instr,
    output logic [4:0]                 D_exc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [4:0]    r_exc   [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Push eligibility looks only at the registered count, so no D_ready -> F_pause path.
    assign w_push  = F_valid && !w_full;
    assign w_pop   = D_ready && !w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
                r_exc[i]   <= '0;
            end
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wp]    <= F_PC;
                // A faulting fetch is stored as a nop so it can never decode as real work.
                r_instr[r_wp] <= (F_exc != 5'd0) ? 32'h0 : F_instr;
                r_exc[r_wp]   <= F_exc;
                r_wp          <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign F_pause = w_full;
    assign D_valid = !w_empty;
    assign D_PC    = w_empty ? 32'h0 : r_pc[r_rp];
    assign D_instr = w_empty ? 32'h0 : r_instr[r_rp];
    assign D_exc   = w_empty ? 5'h0  : r_exc[r_rp];
    assign count   = r_count;

endmodule
